burst_write_master: RTL and testbench

Parametrised Avalon-MM burst write master that streams user data from an internal FIFO into SDRAM through the soft-processor interconnect. It is the successor to the fixed 8-bit master template. It adds configurable data width, FIFO depth, Avalon bursts, a ring-buffer (wrap) mode for continuous crate readout, abort, and progress status. It sits between the readout logic (user side) and the SDRAM controller slave port (Avalon side), configured by control logic or the Nios PIO.

---
 rtl/burst_write_master_pkg.sv | 13 +
 rtl/sc_fifo.sv | 43 ++++
 rtl/burst_write_master.sv | 122 ++++++++++++
 tb/tb_burst_write_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/burst_write_master_pkg.sv
// burst_write_master_pkg: shared state encoding and width helpers for the burst write master
package burst_write_master_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST, FLUSH} state_t;
    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction
    function automatic int burst_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction
    function automatic int used_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock show-ahead FIFO with fill level and one-cycle flush
module sc_fifo
    import burst_write_master_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [used_width(DEPTH)-1:0] used,
    output logic                         full,
    output logic                         empty
);
    localparam int UW = used_width(DEPTH);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = used == UW'(DEPTH);
    assign empty = used == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            used <= used + UW'(do_push) - UW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/burst_write_master.sv
// burst_write_master: Avalon-MM burst write master draining a user FIFO into memory, with ring mode and abort
module burst_write_master
    import burst_write_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_BURST  = 8
) (
    input  logic                                clk_clk,
    input  logic                                reset_reset_n,
    input  logic                                control_fixed_location,
    input  logic                                control_wrap,
    input  logic [ADDR_WIDTH-1:0]               control_write_base,
    input  logic [ADDR_WIDTH-1:0]               control_write_length,
    input  logic                                control_go,
    input  logic                                control_abort,
    output logic                                control_busy,
    output logic                                control_done,
    output logic [15:0]                         control_wrap_count,
    input  logic                                user_write_buffer,
    input  logic [DATA_WIDTH-1:0]               user_buffer_input_data,
    output logic                                user_buffer_full,
    output logic [used_width(FIFO_DEPTH)-1:0]   user_buffer_used,
    output logic [ADDR_WIDTH-1:0]               avm_address,
    output logic                                avm_write,
    output logic [DATA_WIDTH-1:0]               avm_writedata,
    output logic [DATA_WIDTH/8-1:0]             avm_byteenable,
    output logic [burst_width(MAX_BURST)-1:0]   avm_burstcount,
    input  logic                                avm_waitrequest
);
    localparam int LSB = $clog2(bytes_per_word(DATA_WIDTH));
    localparam int BW = burst_width(MAX_BURST);
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] base_q, addr_q, words_q, remaining, n_words;
    logic [BW-1:0] burst_q, beats_left, b_calc;
    logic fixed_q, wrap_q, abort_q, done_q, accept, last_beat, stop, fifo_empty;
    assign n_words = control_write_length >> LSB;
    assign b_calc = fixed_q ? BW'(1) : (remaining >= ADDR_WIDTH'(MAX_BURST) ? BW'(MAX_BURST) : BW'(remaining));
    assign accept = avm_write & ~avm_waitrequest;
    assign last_beat = accept && beats_left == BW'(1);
    assign stop = abort_q | control_abort;
    assign avm_write = state == BURST;
    assign avm_address = addr_q;
    assign avm_burstcount = burst_q;
    assign avm_byteenable = '1;
    assign control_busy = state != IDLE;
    assign control_done = done_q;
    sc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk_clk), .reset_n(reset_reset_n), .push(user_write_buffer), .pop(accept),
        .flush(state == FLUSH), .din(user_buffer_input_data), .dout(avm_writedata),
        .used(user_buffer_used), .full(user_buffer_full), .empty(fifo_empty)
    );
    always_ff @(posedge clk_clk) begin
        state <= reset_reset_n ? state_n : IDLE;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (control_go) state_n = n_words == '0 ? IDLE : WAIT_DATA;
            WAIT_DATA: state_n = control_abort ? FLUSH : (32'(user_buffer_used) >= 32'(b_calc) ? BURST : WAIT_DATA);
            BURST:     if (last_beat) state_n = stop ? FLUSH : (remaining != ADDR_WIDTH'(1) || wrap_q) ? WAIT_DATA : IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            base_q <= '0;
            addr_q <= '0;
            words_q <= '0;
            remaining <= '0;
            burst_q <= '0;
            beats_left <= '0;
            fixed_q <= 1'b0;
            wrap_q <= 1'b0;
            abort_q <= 1'b0;
            done_q <= 1'b0;
            control_wrap_count <= '0;
        end else begin
            case (state)
                IDLE: if (control_go) begin
                    base_q <= (control_write_base >> LSB) << LSB;
                    addr_q <= (control_write_base >> LSB) << LSB;
                    words_q <= n_words;
                    remaining <= n_words;
                    fixed_q <= control_fixed_location;
                    wrap_q <= control_wrap;
                    abort_q <= 1'b0;
                    done_q <= n_words == '0;
                    control_wrap_count <= '0;
                end
                WAIT_DATA: begin
                    burst_q <= b_calc;
                    beats_left <= b_calc;
                end
                BURST: begin
                    if (control_abort) abort_q <= 1'b1;
                    if (accept) begin
                        remaining <= remaining - ADDR_WIDTH'(1);
                        beats_left <= beats_left - BW'(1);
                    end
                    // an aborted run skips the pass bookkeeping and goes straight to FLUSH
                    if (last_beat && !stop) begin
                        if (remaining != ADDR_WIDTH'(1)) begin
                            if (!fixed_q) addr_q <= addr_q + (ADDR_WIDTH'(burst_q) << LSB);
                        end else if (wrap_q) begin
                            addr_q <= base_q;
                            remaining <= words_q;
                            if (control_wrap_count != 16'hFFFF) control_wrap_count <= control_wrap_count + 16'd1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    done_q <= 1'b1;
                    abort_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_burst_write_master.sv
// tb_burst_write_master: directed checks of bursts, trickle, fixed, wrap+abort, FIFO full and reset
module tb_burst_write_master;
    logic clk = 1'b0;
    logic reset_reset_n = 1'b0;
    logic control_fixed_location = 1'b0, control_wrap = 1'b0, control_go = 1'b0, control_abort = 1'b0;
    logic [31:0] control_write_base = '0, control_write_length = '0;
    logic control_busy, control_done;
    logic [15:0] control_wrap_count;
    logic user_write_buffer = 1'b0;
    logic [31:0] user_buffer_input_data = '0;
    logic user_buffer_full;
    logic [4:0] user_buffer_used;
    logic [31:0] avm_address, avm_writedata;
    logic avm_write;
    logic [3:0] avm_byteenable, avm_burstcount;
    logic avm_waitrequest = 1'b0;
    int passed = 0, total = 0;
    logic [31:0] log_addr[$], log_data[$], log_bc[$];

    burst_write_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(16), .MAX_BURST(8)) dut (
        .clk_clk(clk), .reset_reset_n(reset_reset_n),
        .control_fixed_location(control_fixed_location), .control_wrap(control_wrap),
        .control_write_base(control_write_base), .control_write_length(control_write_length),
        .control_go(control_go), .control_abort(control_abort), .control_busy(control_busy),
        .control_done(control_done), .control_wrap_count(control_wrap_count),
        .user_write_buffer(user_write_buffer), .user_buffer_input_data(user_buffer_input_data),
        .user_buffer_full(user_buffer_full), .user_buffer_used(user_buffer_used),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_reset_n && avm_write && !avm_waitrequest) begin
            log_addr.push_back(avm_address);
            log_data.push_back(avm_writedata);
            log_bc.push_back(32'(avm_burstcount));
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        user_write_buffer = 1'b1;
        user_buffer_input_data = d;
        tick();
        user_write_buffer = 1'b0;
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] len, input logic fixed, input logic wrap);
        control_write_base = base;
        control_write_length = len;
        control_fixed_location = fixed;
        control_wrap = wrap;
        control_go = 1'b1;
        tick();
        control_go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (control_busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_within_budget", control_busy, 1'b0);
        check("done_at_idle", control_done, 1'b1);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_bc.delete();
    endtask

    initial begin
        repeat (2) tick();
        check("rst_busy", control_busy, 1'b0);
        check("rst_done", control_done, 1'b0);
        check("rst_write", avm_write, 1'b0);
        check("rst_used", user_buffer_used, 5'd0);
        check("rst_full", user_buffer_full, 1'b0);
        check("rst_wrap_count", control_wrap_count, 16'd0);
        check("rst_burstcount", avm_burstcount, 4'd0);
        reset_reset_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            push(32'hA000 + 32'(i));
            if (i == 14) check("not_full_at_15", user_buffer_full, 1'b0);
            if (i == 15) check("full_at_16", user_buffer_full, 1'b1);
        end
        check("used_capped_16", user_buffer_used, 5'd16);
        clear_log();
        start(32'h1000, 32'd64, 1'b0, 1'b0);
        check("busy_after_go", control_busy, 1'b1);
        check("no_write_t1", avm_write, 1'b0);
        check("done_cleared_by_go", control_done, 1'b0);
        tick();
        check("write_t2", avm_write, 1'b1);
        check("first_addr", avm_address, 32'h1000);
        check("first_burstcount", avm_burstcount, 4'd8);
        wait_idle(200);
        check("t1_beats", log_data.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check("t1_addr", log_addr[i], i < 8 ? 32'h1000 : 32'h1020);
            check("t1_data", log_data[i], 32'hA000 + 32'(i));
            check("t1_bc", log_bc[i], 32'd8);
        end
        check("t1_used_empty", user_buffer_used, 5'd0);

        clear_log();
        start(32'h2003, 32'd23, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            push(32'hB000 + 32'(k));
            if (k < 4) begin
                repeat (3) tick();
                check("trickle_no_early_write", avm_write, 1'b0);
            end
        end
        wait_idle(200);
        check("t2_beats", log_data.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_addr", log_addr[i], 32'h2000);
            check("t2_data", log_data[i], 32'hB000 + 32'(i));
            check("t2_bc", log_bc[i], 32'd5);
        end

        clear_log();
        for (int i = 0; i < 3; i++) push(32'hC000 + 32'(i));
        start(32'h3000, 32'd12, 1'b1, 1'b0);
        wait_idle(200);
        check("t3_beats", log_data.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("t3_addr", log_addr[i], 32'h3000);
            check("t3_data", log_data[i], 32'hC000 + 32'(i));
            check("t3_bc", log_bc[i], 32'd1);
        end

        clear_log();
        start(32'h5000, 32'd3, 1'b0, 1'b0);
        check("zero_len_busy", control_busy, 1'b0);
        check("zero_len_done", control_done, 1'b1);
        control_abort = 1'b1;
        tick();
        control_abort = 1'b0;
        check("idle_abort_ignored", control_busy, 1'b0);
        control_abort = 1'b1;
        start(32'h5000, 32'd16, 1'b0, 1'b0);
        check("go_beats_abort", control_busy, 1'b1);
        check("go_clears_done", control_done, 1'b0);
        control_abort = 1'b0;
        start(32'h5000, 32'd0, 1'b0, 1'b0);
        check("go_while_busy_ignored", control_busy, 1'b1);
        control_abort = 1'b1;
        tick();
        control_abort = 1'b0;
        check("flush_still_busy", control_busy, 1'b1);
        check("flush_done_low", control_done, 1'b0);
        tick();
        check("wait_abort_idle", control_busy, 1'b0);
        check("wait_abort_done", control_done, 1'b1);
        check("wait_abort_no_beats", log_data.size(), 0);

        clear_log();
        start(32'h4000, 32'd32, 1'b0, 1'b1);
        begin
            int cyc = 0;
            bit aborted = 0;
            logic [31:0] d = 32'hD000;
            while (cyc < 3000 && control_busy) begin
                avm_waitrequest = 1'($urandom_range(0, 1));
                user_write_buffer = !aborted && !user_buffer_full;
                user_buffer_input_data = d;
                if (user_write_buffer) d++;
                control_abort = !aborted && log_data.size() >= 19 && avm_write;
                if (control_abort) aborted = 1;
                tick();
                cyc++;
            end
        end
        user_write_buffer = 1'b0;
        control_abort = 1'b0;
        avm_waitrequest = 1'b0;
        check("wrap_idle", control_busy, 1'b0);
        check("wrap_done", control_done, 1'b1);
        check("wrap_count", control_wrap_count, 16'd2);
        check("wrap_flushed", user_buffer_used, 5'd0);
        check("wrap_beats", log_data.size(), 24);
        for (int i = 0; i < 24; i++) begin
            check("wrap_addr", log_addr[i], 32'h4000);
            check("wrap_data", log_data[i], 32'hD000 + 32'(i));
        end

        for (int i = 0; i < 8; i++) push(32'hE000 + 32'(i));
        avm_waitrequest = 1'b1;
        start(32'h6000, 32'd32, 1'b0, 1'b0);
        tick();
        check("hold_write", avm_write, 1'b1);
        tick();
        check("hold_addr", avm_address, 32'h6000);
        check("hold_data", avm_writedata, 32'hE000);
        check("hold_bc", avm_burstcount, 4'd8);
        reset_reset_n = 1'b0;
        tick();
        check("midrst_write", avm_write, 1'b0);
        check("midrst_busy", control_busy, 1'b0);
        check("midrst_done", control_done, 1'b0);
        check("midrst_used", user_buffer_used, 5'd0);
        reset_reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
